// File: rtl/pipe_tag_tracker.sv
// Sequence-tag tracker for an in-order pipeline of STAGES stages with per-stage advance/retire/kill.
// Define PIPE_TAG_CHECK_EN to build the sticky ordering checker (err/err_stage); otherwise both are tied 0.
module pipe_tag_tracker #(
  parameter int STAGES = 5,
  parameter int TAG_W  = 6,
  parameter int CNT_W  = $clog2(STAGES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [STAGES-1:0]          advance,
  input  logic [STAGES-1:0]          retire,
  input  logic [STAGES-1:0]          kill,
  output logic [STAGES*TAG_W-1:0]    tag,
  output logic [STAGES-1:0]          valid,
  output logic [CNT_W-1:0]           inflight,
  output logic [TAG_W-1:0]           next_tag,
  output logic                       err,
  output logic [$clog2(STAGES)-1:0]  err_stage
);

  localparam int SW = $clog2(STAGES);

  logic [TAG_W-1:0]             seq_q, seq_d;
  logic [STAGES-1:0][TAG_W-1:0] raw_q, raw_d;
  logic [STAGES-1:0]            v_q, v_d;

  // Tag 0 is reserved for "empty", so the all-ones tag wraps to 1.
  function automatic logic [TAG_W-1:0] inc(input logic [TAG_W-1:0] x);
    return (x == {TAG_W{1'b1}}) ? TAG_W'(1) : x + 1'b1;
  endfunction

  always_comb begin
    seq_d = seq_q;
    raw_d = raw_q;
    v_d   = v_q;
    if (advance[0]) begin
      seq_d    = inc(seq_q);
      raw_d[0] = inc(seq_q);
    end
    for (int i = 1; i < STAGES; i++) begin
      if (advance[i]) raw_d[i] = raw_q[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      if (kill[i])         v_d[i] = 1'b0;
      else if (advance[i]) v_d[i] = 1'b1;
      else if (retire[i])  v_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q <= '0;
      raw_q <= '0;
      v_q   <= '0;
    end else begin
      seq_q <= seq_d;
      raw_q <= raw_d;
      v_q   <= v_d;
    end
  end

  always_comb begin
    tag      = '0;
    inflight = '0;
    for (int i = 0; i < STAGES; i++) begin
      tag[i*TAG_W +: TAG_W] = v_q[i] ? raw_q[i] : '0;
      inflight              = inflight + CNT_W'(v_q[i]);
    end
  end

  assign valid    = v_q;
  assign next_tag = inc(seq_q);

`ifdef PIPE_TAG_CHECK_EN
  logic          err_q, err_d;
  logic [SW-1:0] err_stage_q, err_stage_d;
  logic [STAGES-1:0] viol;
  logic [STAGES-1:0] adv_next;
  logic [SW-1:0]     first_stage;

  // adv_next[i] is advance[i+1]; the last stage has no successor so it reads 0.
  assign adv_next = advance >> 1;

  always_comb begin
    viol        = '0;
    first_stage = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (i > 0 && advance[i] && !v_q[(i > 0) ? i-1 : 0] && !kill[i]) viol[i] = 1'b1;
      if (advance[i] && v_q[i] && !retire[i] && !kill[i] && !adv_next[i]) viol[i] = 1'b1;
    end
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (viol[i]) first_stage = SW'(i);
    end
    err_d       = err_q;
    err_stage_d = err_stage_q;
    if (!err_q && (|viol)) begin
      err_d       = 1'b1;
      err_stage_d = first_stage;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q       <= 1'b0;
      err_stage_q <= '0;
    end else begin
      err_q       <= err_d;
      err_stage_q <= err_stage_d;
    end
  end

  assign err       = err_q;
  assign err_stage = err_stage_q;
`else
  assign err       = 1'b0;
  assign err_stage = '0;
`endif

endmodule
